pll_reset_sequencer: RTL and testbench
======================================

// Module: pll_reset_sequencer
// PURPOSE
//  Supervises a Gowin rPLL from the always-present 27 MHz crystal clock. Pulses the PLL reset,
//  waits for lock with timeout and bounded retries, debounces lock, then releases NUM_DOMAINS
//  per-domain resets in staggered order (domain 0 first). On loss of lock it re-asserts all
//  domain resets and restarts the PLL. Downstream domains resynchronise domain_rst_o locally.
// PARAMETERS
//  NUM_DOMAINS          2      number of sequenced reset outputs (>=1)
//  PLL_RST_CYCLES       16     pll_reset_o pulse length, clk cycles (>=1)
//  LOCK_TIMEOUT_CYCLES  65536  cycles in S_WAIT_LOCK before a retry
//  LOCK_STABLE_CYCLES   1024   consecutive synced-lock cycles required before release (>=1)
//  RELEASE_GAP_CYCLES   64     cycles between successive domain releases, and last release->ready_o (>=1)
//  MAX_RETRIES          3      timeouts tolerated; reaching it enters S_FAIL (>=1)
//  LOSS_CNT_W           8      lock-loss counter width
// PORTS
//  clk              in   1             27 MHz crystal clock
//  reset            in   1             synchronous, active-high
//  pll_lock_i       in   1             rPLL LOCK, asynchronous to clk
//  pll_reset_o      out  1             to rPLL RESET
//  domain_rst_o     out  NUM_DOMAINS   per-domain reset, active-high
//  ready_o          out  1             all domains released, lock good
//  fail_o           out  1             sticky: retries exhausted
//  retry_cnt_o      out  clog2(MAX_RETRIES+1)  timeouts in current bring-up
//  lock_loss_cnt_o  out  LOSS_CNT_W    lock losses after release began (see CONFIGURATION)
// BEHAVIOUR
//  - One clock, synchronous active-high reset. All outputs registered.
//  - Reset values: pll_reset_o=1, domain_rst_o=all 1, ready_o=0, fail_o=0, retry_cnt_o=0,
//    lock_loss_cnt_o=0, state=S_PLL_RST, cycle counter=0, domain index=0. Reset overrides all, any state.
//  - pll_lock_i passes a 2-FF synchroniser -> lock_s (2-cycle latency). FSM uses lock_s only.
//  - S_PLL_RST: pll_reset_o=1 for exactly PLL_RST_CYCLES cycles -> S_WAIT_LOCK, counter cleared.
//  - S_WAIT_LOCK: pll_reset_o=0, counter++. lock_s=1 -> S_STABLE (counter cleared). Else at
//    counter==LOCK_TIMEOUT_CYCLES-1: retry_cnt++; if new value==MAX_RETRIES -> S_FAIL, else S_PLL_RST.
//    lock_s=1 wins over a simultaneous timeout.
//  - S_STABLE: counter++ while lock_s=1; lock_s=0 -> S_WAIT_LOCK, counter cleared (timeout restarts).
//    At counter==LOCK_STABLE_CYCLES-1 with lock_s=1 -> S_RELEASE; domain_rst_o[0] deasserts on entry.
//  - S_RELEASE: every RELEASE_GAP_CYCLES, deassert next domain_rst_o[idx]; RELEASE_GAP_CYCLES after
//    last domain -> S_RUN, ready_o=1, retry_cnt_o cleared. Released bits stay low.
//  - S_RUN: hold. lock_s=0 in S_RELEASE or S_RUN -> next cycle all domain_rst_o=1, ready_o=0,
//    idx=0, retry_cnt_o=0, lock-loss counter++, -> S_PLL_RST. pll_lock_i fall -> domain_rst_o high in 3 cycles.
//  - S_FAIL: pll_reset_o=1, domain_rst_o all 1, ready_o=0, fail_o=1; exits only via reset.
//  - Counters sized clog2 of largest cycle parameter; no wrap possible within a state.
// CONFIGURATION
//  PLL_RESET_SEQ_LOSS_COUNT_EN defined: lock_loss_cnt_o counts lock-loss events (S_RELEASE/S_RUN
//  only), saturating at 2**LOSS_CNT_W-1; cleared only by reset.
//  Not defined: counter not built, lock_loss_cnt_o tied to 0; all other behaviour identical.
// STRUCTURE
//  Package pll_reset_seq_pkg: state enum {S_PLL_RST,S_WAIT_LOCK,S_STABLE,S_RELEASE,S_RUN,S_FAIL},
//  width helper function (clog2-based) for counter/retry widths.
//  Sub-module: sync_2ff (lock synchroniser). FSM, counters, release index in this module.
// TESTING  (NUM_DOMAINS=3, PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8,
//           RELEASE_GAP_CYCLES=3, MAX_RETRIES=2)
//  1 Reset released, lock rises cycle 10, stays -> pll_reset_o high 4 cycles; domain_rst_o[0..2]
//    fall 3 cycles apart starting 8 cycles after lock_s=1; ready_o 3 cycles after domain 2.
//  2 Lock low 1 cycle at stable count 5 -> no release; release 8 cycles after lock_s returns high.
//  3 Lock never asserts -> exactly 2 pll_reset_o pulses of 4 cycles, retry_cnt_o 1 then 2, fail_o=1,
//    domain_rst_o stays 3'b111 indefinitely.
//  4 In S_RUN drop pll_lock_i -> domain_rst_o=3'b111 within 3 cycles, ready_o=0, 4-cycle pll_reset_o
//    pulse, lock_loss_cnt_o 0->1 (macro on); relock -> full sequence repeats.
//  5 Reset asserted after domain 1 released -> next cycle every output at reset value.
//  6 Macro undefined, run scenario 4 -> lock_loss_cnt_o stays 0; all other outputs match scenario 4.

Source files
------------

// File: rtl/pll_reset_seq_pkg.sv
// Shared types and width helpers for the PLL reset sequencer.
// Also used by pll_reset_sequencer, whose optional feature is PLL_RESET_SEQ_LOSS_COUNT_EN.
package pll_reset_seq_pkg;

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int width_for(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for slow level signals crossing into clk.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// rPLL supervisor: reset pulse, lock wait with retries, lock debounce, staggered domain release.
// Define PLL_RESET_SEQ_LOSS_COUNT_EN to build the saturating lock-loss counter.
module pll_reset_sequencer
    import pll_reset_seq_pkg::*;
#(
    parameter int NUM_DOMAINS         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int RELEASE_GAP_CYCLES  = 64,
    parameter int MAX_RETRIES         = 3,
    parameter int LOSS_CNT_W          = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  pll_lock_i,
    output logic                                  pll_reset_o,
    output logic [NUM_DOMAINS-1:0]                domain_rst_o,
    output logic                                  ready_o,
    output logic                                  fail_o,
    output logic [width_for(MAX_RETRIES+1)-1:0]   retry_cnt_o,
    output logic [LOSS_CNT_W-1:0]                 lock_loss_cnt_o
);

    localparam int CNT_MAX = max2(max2(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES),
                                  max2(LOCK_STABLE_CYCLES, RELEASE_GAP_CYCLES));
    localparam int CNT_W   = width_for(CNT_MAX);
    localparam int RET_W   = width_for(MAX_RETRIES + 1);
    localparam int IDX_W   = width_for(NUM_DOMAINS + 1);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(RELEASE_GAP_CYCLES - 1);

    logic                   lock_s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [RET_W-1:0]       retry_q, retry_d, retry_inc;
    logic                   pll_rst_q, pll_rst_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   ready_q, ready_d;
    logic                   fail_q, fail_d;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pll_lock_i),
        .q     (lock_s)
    );

    assign retry_inc = retry_q + RET_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_PLL_RST;
            cnt_q     <= '0;
            idx_q     <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            dom_q     <= '1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            pll_rst_q <= pll_rst_d;
            dom_q     <= dom_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        pll_rst_d = pll_rst_q;
        dom_d     = dom_q;
        ready_d   = ready_q;
        fail_d    = fail_q;

        unique case (state_q)
            S_PLL_RST: begin
                pll_rst_d = 1'b1;
                dom_d     = '1;
                ready_d   = 1'b0;
                if (cnt_q == RST_LAST) begin
                    state_d   = S_WAIT_LOCK;
                    cnt_d     = '0;
                    pll_rst_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_WAIT_LOCK: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Lock takes priority over a timeout landing in the same cycle.
                if (lock_s) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    cnt_d     = '0;
                    retry_d   = retry_inc;
                    pll_rst_d = 1'b1;
                    if (retry_inc == RET_W'(MAX_RETRIES)) begin
                        state_d = S_FAIL;
                        fail_d  = 1'b1;
                    end else begin
                        state_d = S_PLL_RST;
                    end
                end
            end

            S_STABLE: begin
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STB_LAST) begin
                    state_d  = S_RELEASE;
                    cnt_d    = '0;
                    dom_d[0] = 1'b0;
                    idx_d    = IDX_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_RELEASE, S_RUN: begin
                if (!lock_s) begin
                    state_d   = S_PLL_RST;
                    cnt_d     = '0;
                    idx_d     = '0;
                    retry_d   = '0;
                    pll_rst_d = 1'b1;
                    dom_d     = '1;
                    ready_d   = 1'b0;
                end else if (state_q == S_RELEASE) begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d = '0;
                        // idx points at the next domain; reaching NUM_DOMAINS means the last gap expired.
                        if (idx_q == IDX_W'(NUM_DOMAINS)) begin
                            state_d = S_RUN;
                            ready_d = 1'b1;
                            retry_d = '0;
                        end else begin
                            for (int i = 0; i < NUM_DOMAINS; i++) begin
                                if (idx_q == IDX_W'(i)) dom_d[i] = 1'b0;
                            end
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_FAIL: begin
                pll_rst_d = 1'b1;
                dom_d     = '1;
                ready_d   = 1'b0;
                fail_d    = 1'b1;
            end

            default: begin
                state_d   = S_PLL_RST;
                cnt_d     = '0;
                idx_d     = '0;
                pll_rst_d = 1'b1;
                dom_d     = '1;
                ready_d   = 1'b0;
            end
        endcase
    end

`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    logic                  loss_evt;
    logic [LOSS_CNT_W-1:0] loss_q;

    assign loss_evt = !lock_s && (state_q == S_RELEASE || state_q == S_RUN);

    always_ff @(posedge clk) begin
        if (reset)
            loss_q <= '0;
        else if (loss_evt && loss_q != '1)
            loss_q <= loss_q + LOSS_CNT_W'(1);
    end

    assign lock_loss_cnt_o = loss_q;
`else
    assign lock_loss_cnt_o = '0;
`endif

    assign pll_reset_o  = pll_rst_q;
    assign domain_rst_o = dom_q;
    assign ready_o      = ready_q;
    assign fail_o       = fail_q;
    assign retry_cnt_o  = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench: bring-up, debounce glitch, retry exhaustion, lock loss/relock, mid-release reset.
module tb_pll_reset_sequencer;

    localparam int ND = 3;

`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    localparam int EXP_LOSS1 = 1;
    localparam int EXP_LOSS2 = 2;
`else
    localparam int EXP_LOSS1 = 0;
    localparam int EXP_LOSS2 = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          pll_lock_i;
    logic          pll_reset_o;
    logic [ND-1:0] domain_rst_o;
    logic          ready_o;
    logic          fail_o;
    logic [1:0]    retry_cnt_o;
    logic [7:0]    lock_loss_cnt_o;

    int cyc;
    int n_chk;
    int n_err;

    pll_reset_sequencer #(
        .NUM_DOMAINS         (ND),
        .PLL_RST_CYCLES      (4),
        .LOCK_TIMEOUT_CYCLES (32),
        .LOCK_STABLE_CYCLES  (8),
        .RELEASE_GAP_CYCLES  (3),
        .MAX_RETRIES         (2),
        .LOSS_CNT_W          (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pll_lock_i      (pll_lock_i),
        .pll_reset_o     (pll_reset_o),
        .domain_rst_o    (domain_rst_o),
        .ready_o         (ready_o),
        .fail_o          (fail_o),
        .retry_cnt_o     (retry_cnt_o),
        .lock_loss_cnt_o (lock_loss_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    // Sample point cyc=0 shows the state left by the last reset edge.
    task automatic apply_reset();
        reset      = 1'b1;
        pll_lock_i = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pll"},   32'(pll_reset_o),     32'd1);
        chk({tag, "_dom"},   32'(domain_rst_o),    32'd7);
        chk({tag, "_rdy"},   32'(ready_o),         32'd0);
        chk({tag, "_fail"},  32'(fail_o),          32'd0);
        chk({tag, "_retry"}, 32'(retry_cnt_o),     32'd0);
        chk({tag, "_loss"},  32'(lock_loss_cnt_o), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        cyc   = 0;

        // Scenario 1: clean bring-up, lock at cycle 10
        apply_reset();
        chk_reset_vals("s1_rst");
        run_to(3);  chk("s1_pll_hi",  32'(pll_reset_o), 32'd1);
        run_to(4);  chk("s1_pll_lo",  32'(pll_reset_o), 32'd0);
        run_to(10); pll_lock_i = 1'b1;
        run_to(20); chk("s1_dom20",   32'(domain_rst_o), 32'd7);
        run_to(21); chk("s1_dom0",    32'(domain_rst_o), 32'd6);
        run_to(23); chk("s1_dom23",   32'(domain_rst_o), 32'd6);
        run_to(24); chk("s1_dom1",    32'(domain_rst_o), 32'd4);
        run_to(26); chk("s1_dom26",   32'(domain_rst_o), 32'd4);
        run_to(27); chk("s1_dom2",    32'(domain_rst_o), 32'd0);
        run_to(29); chk("s1_rdy29",   32'(ready_o), 32'd0);
        run_to(30); chk("s1_rdy30",   32'(ready_o), 32'd1);
                    chk("s1_retry",   32'(retry_cnt_o), 32'd0);

        // Scenario 4/6: lock loss in S_RUN, relock
        run_to(40); pll_lock_i = 1'b0;
        run_to(42); chk("s4_dom42",   32'(domain_rst_o), 32'd0);
                    chk("s4_rdy42",   32'(ready_o), 32'd1);
        run_to(43); chk("s4_dom43",   32'(domain_rst_o), 32'd7);
                    chk("s4_rdy43",   32'(ready_o), 32'd0);
                    chk("s4_pll43",   32'(pll_reset_o), 32'd1);
                    chk("s4_loss1",   32'(lock_loss_cnt_o), 32'(EXP_LOSS1));
        run_to(46); chk("s4_pll46",   32'(pll_reset_o), 32'd1);
        run_to(47); chk("s4_pll47",   32'(pll_reset_o), 32'd0);
        run_to(50); pll_lock_i = 1'b1;
        run_to(60); chk("s4_dom60",   32'(domain_rst_o), 32'd7);
        run_to(61); chk("s4_dom0",    32'(domain_rst_o), 32'd6);
        run_to(64); chk("s4_dom1",    32'(domain_rst_o), 32'd4);
        run_to(67); chk("s4_dom2",    32'(domain_rst_o), 32'd0);
        run_to(70); chk("s4_rdy",     32'(ready_o), 32'd1);
                    chk("s4_retry",   32'(retry_cnt_o), 32'd0);

        // Second loss, then Scenario 5: reset right after domain 1 releases
        run_to(80); pll_lock_i = 1'b0;
        run_to(83); chk("s5_loss2",   32'(lock_loss_cnt_o), 32'(EXP_LOSS2));
                    chk("s5_dom83",   32'(domain_rst_o), 32'd7);
        run_to(90); pll_lock_i = 1'b1;
        run_to(101); chk("s5_dom0",   32'(domain_rst_o), 32'd6);
        run_to(104); chk("s5_dom1",   32'(domain_rst_o), 32'd4);
        run_to(105); reset = 1'b1;
        run_to(106); chk_reset_vals("s5_rst");
        reset = 1'b0;

        // Scenario 2: one-cycle lock glitch at stable count 5
        apply_reset();
        run_to(10); pll_lock_i = 1'b1;
        run_to(16); pll_lock_i = 1'b0;
        run_to(17); pll_lock_i = 1'b1;
        run_to(21); chk("s2_dom21",   32'(domain_rst_o), 32'd7);
        run_to(27); chk("s2_dom27",   32'(domain_rst_o), 32'd7);
        run_to(28); chk("s2_dom0",    32'(domain_rst_o), 32'd6);
        run_to(31); chk("s2_dom1",    32'(domain_rst_o), 32'd4);
        run_to(34); chk("s2_dom2",    32'(domain_rst_o), 32'd0);
        run_to(36); chk("s2_rdy36",   32'(ready_o), 32'd0);
        run_to(37); chk("s2_rdy37",   32'(ready_o), 32'd1);

        // Scenario 3: lock never comes, retries exhausted
        apply_reset();
        run_to(35); chk("s3_pll35",   32'(pll_reset_o), 32'd0);
                    chk("s3_retry35", 32'(retry_cnt_o), 32'd0);
        run_to(36); chk("s3_pll36",   32'(pll_reset_o), 32'd1);
                    chk("s3_retry36", 32'(retry_cnt_o), 32'd1);
                    chk("s3_fail36",  32'(fail_o), 32'd0);
        run_to(39); chk("s3_pll39",   32'(pll_reset_o), 32'd1);
        run_to(40); chk("s3_pll40",   32'(pll_reset_o), 32'd0);
        run_to(71); chk("s3_pll71",   32'(pll_reset_o), 32'd0);
                    chk("s3_fail71",  32'(fail_o), 32'd0);
        run_to(72); chk("s3_pll72",   32'(pll_reset_o), 32'd1);
                    chk("s3_retry72", 32'(retry_cnt_o), 32'd2);
                    chk("s3_fail72",  32'(fail_o), 32'd1);
                    chk("s3_dom72",   32'(domain_rst_o), 32'd7);
        run_to(80); pll_lock_i = 1'b1;
        run_to(150); chk("s3_fail150", 32'(fail_o), 32'd1);
                     chk("s3_dom150",  32'(domain_rst_o), 32'd7);
                     chk("s3_pll150",  32'(pll_reset_o), 32'd1);
                     chk("s3_rdy150",  32'(ready_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
